// File: rtl/fetch_sequencer_if.sv
// Instruction-memory read bus between the fetch sequencer (master) and memory (slave).
interface fetch_sequencer_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] mem_addr_o;
    logic                  mem_rd_no;
    logic [DATA_WIDTH-1:0] mem_data_i;
    logic                  mem_rdy_i;

    modport master (
        output mem_addr_o,
        output mem_rd_no,
        input  mem_data_i,
        input  mem_rdy_i
    );

    modport slave (
        input  mem_addr_o,
        input  mem_rd_no,
        output mem_data_i,
        output mem_rdy_i
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: samples the PC, reads memory, loads the IR, then strobes a PC increment.
// Optional FETCH_TIMEOUT_EN aborts a read that sees no ready within TIMEOUT_CYCLES wait edges.
module fetch_sequencer #(
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  fetch_ni,
    input  logic [DATA_WIDTH-1:0] pc_i,
    output logic                  pc_inc_no,
    fetch_sequencer_if.master     mem,
    output logic [DATA_WIDTH-1:0] ir_o,
    output logic                  ir_valid_o,
    output logic                  busy_o,
    output logic                  fault_o
);
    // state | meaning
    // IDLE  | waiting for fetch_ni low
    // ADDR  | address registered, read strobe asserted on the next edge
    // WAIT  | read outstanding, waiting for mem_rdy_i
    // DONE  | IR loaded, pc_inc_no low for this one cycle
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0] state;
    logic       timeout_hit;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("fetch_sequencer: TIMEOUT_CYCLES must be >= 1");
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt;

    // The abort edge is the TIMEOUT_CYCLES-th WAIT edge, so the count never passes CNT_LAST.
    assign timeout_hit = (wait_cnt == CNT_LAST);

    always_ff @(negedge clk_i) begin
        if (!reset_ni) begin
            wait_cnt <= '0;
            fault_o  <= 1'b0;
        end else begin
            if (state == ST_IDLE && !fetch_ni) begin
                fault_o <= 1'b0;
            end
            if (state == ST_ADDR) begin
                wait_cnt <= '0;
            end else if (state == ST_WAIT && !mem.mem_rdy_i) begin
                if (timeout_hit) begin
                    fault_o <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                end
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign fault_o     = 1'b0;
`endif

    always_ff @(negedge clk_i) begin
        if (!reset_ni) begin
            state          <= ST_IDLE;
            mem.mem_addr_o <= '0;
            mem.mem_rd_no  <= 1'b1;
            pc_inc_no      <= 1'b1;
            ir_o           <= '0;
            ir_valid_o     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fetch_ni) begin
                        mem.mem_addr_o <= pc_i;
                        ir_valid_o     <= 1'b0;
                        state          <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    mem.mem_rd_no <= 1'b0;
                    state         <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Ready takes priority over an abort landing on the same edge.
                    if (mem.mem_rdy_i) begin
                        ir_o          <= mem.mem_data_i;
                        ir_valid_o    <= 1'b1;
                        mem.mem_rd_no <= 1'b1;
                        pc_inc_no     <= 1'b0;
                        state         <= ST_DONE;
                    end else if (timeout_hit) begin
                        mem.mem_rd_no <= 1'b1;
                        state         <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    pc_inc_no <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o = (state != ST_IDLE);
endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer with a behavioural PC and memory responder.
module tb_fetch_sequencer;
    localparam int DW = 16;
`ifdef FETCH_TIMEOUT_EN
    localparam int TMO  = 4;
    localparam int DMAX = 4;
`else
    localparam int TMO  = 15;
    localparam int DMAX = 8;
`endif

    typedef struct {
        int          delay;
        logic [DW-1:0] data;
    } plan_t;

    typedef struct {
        logic [DW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk_i    = 1'b0;
    logic          reset_ni = 1'b0;
    logic          fetch_ni = 1'b1;
    logic [DW-1:0] pc_model = '0;
    logic          pc_inc_no;
    logic [DW-1:0] ir_o;
    logic          ir_valid_o;
    logic          busy_o;
    logic          fault_o;

    int     tests = 0;
    int     fails = 0;
    plan_t  plan_q[$];
    exp_t   exp_q[$];
    exp_t   mon_e;
    int     pulse_cnt = 0;
    longint cyc = 0;
    longint pulse_cyc[$];
    bit     force_rdy = 1'b0;
    int     load_seq = 0;
    int     load_done = 0;
    logic [DW-1:0] load_val = '0;
    int     wait_k = 0;
    bit     served = 1'b0;
    logic   prev_inc = 1'b1;

    fetch_sequencer_if #(.DATA_WIDTH(DW)) mem_bus ();

    fetch_sequencer #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i      (clk_i),
        .reset_ni   (reset_ni),
        .fetch_ni   (fetch_ni),
        .pc_i       (pc_model),
        .pc_inc_no  (pc_inc_no),
        .mem        (mem_bus.master),
        .ir_o       (ir_o),
        .ir_valid_o (ir_valid_o),
        .busy_o     (busy_o),
        .fault_o    (fault_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic void chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void chk1(string name, logic act, logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endfunction

    function automatic void chki(string name, longint act, longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    // PC: loads on request, otherwise counts up when it samples the increment strobe.
    always @(negedge clk_i) begin
        if (load_seq != load_done) begin
            pc_model  <= load_val;
            load_done <= load_seq;
        end else if (pc_inc_no === 1'b0) begin
            pc_model <= pc_model + 1'b1;
        end
    end

    // Memory: raises ready once the read strobe has been low for the planned number of cycles.
    always @(posedge clk_i) begin
        if (mem_bus.mem_rd_no === 1'b0) begin
            wait_k++;
            if (plan_q.size() > 0 && wait_k >= plan_q[0].delay) begin
                mem_bus.mem_rdy_i  = 1'b1;
                mem_bus.mem_data_i = plan_q[0].data;
                served = 1'b1;
            end else begin
                mem_bus.mem_rdy_i  = 1'b0;
                mem_bus.mem_data_i = DW'($urandom);
            end
        end else begin
            if (served) void'(plan_q.pop_front());
            served = 1'b0;
            wait_k = 0;
            mem_bus.mem_rdy_i  = force_rdy;
            mem_bus.mem_data_i = DW'($urandom);
        end
    end

    // Monitor: every increment pulse must match the oldest outstanding expected fetch.
    always @(posedge clk_i) begin
        cyc++;
        if (reset_ni === 1'b1 && pc_inc_no === 1'b0) begin
            if (prev_inc === 1'b0) begin
                tests++;
                fails++;
                $display("FAIL inc_width: pc_inc_no low for 2+ cycles, expected exactly 1");
            end else begin
                pulse_cnt++;
                pulse_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_inc: pulse with ir_o=0x%0h, expected no pulse", ir_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("sb_ir", ir_o, mon_e.data);
                    chk("sb_addr", mem_bus.mem_addr_o, mon_e.addr);
                    chk1("sb_ir_valid", ir_valid_o, 1'b1);
                end
            end
        end
        prev_inc = pc_inc_no;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pc_load(input logic [DW-1:0] v);
        load_val = v;
        load_seq++;
        tick();
    endtask

    task automatic wait_idle(input string name);
        int guard = 0;
        while (busy_o !== 1'b0 && guard < 300) begin
            tick();
            guard++;
        end
        if (guard >= 300) begin
            tests++;
            fails++;
            $display("FAIL %s: busy_o still %b after 300 cycles, expected 0", name, busy_o);
        end
    endtask

    // One fetch; ok=0 means the read is expected to time out.
    task automatic run_fetch(input string name, input int d, input logic [DW-1:0] data,
                             input bit ok, input bit do_load, input logic [DW-1:0] lval);
        logic [DW-1:0] pc0;
        logic [DW-1:0] ir0;
        logic [DW-1:0] pexp;
        int n_busy, n_rd, p0, guard;
        pc0 = pc_model;
        ir0 = ir_o;
        p0  = pulse_cnt;
        plan_q.push_back('{d, data});
        if (ok) exp_q.push_back('{pc0, data});
        fetch_ni = 1'b0;
        tick();
        fetch_ni = 1'b1;
        if (do_load) begin
            load_val = lval;
            load_seq++;
        end
        n_busy = 0;
        n_rd   = 0;
        guard  = 0;
        while (busy_o === 1'b1 && guard < 300) begin
            n_busy++;
            if (mem_bus.mem_rd_no === 1'b0) n_rd++;
            tick();
            guard++;
        end
        if (guard >= 300) begin
            tests++;
            fails++;
            $display("FAIL %s_hang: fetch never returned to idle, expected idle", name);
        end
        if (ok) begin
            pexp = (do_load ? lval : pc0) + 1'b1;
            chki({name, "_busy_cycles"}, n_busy, d + 2);
            chki({name, "_rd_cycles"}, n_rd, d);
            chki({name, "_pulses"}, pulse_cnt, p0 + 1);
            chk({name, "_pc"}, pc_model, pexp);
            chk1({name, "_valid"}, ir_valid_o, 1'b1);
            chk1({name, "_fault"}, fault_o, 1'b0);
        end else begin
            chki({name, "_busy_cycles"}, n_busy, TMO + 1);
            chki({name, "_rd_cycles"}, n_rd, TMO);
            chki({name, "_pulses"}, pulse_cnt, p0);
            chk({name, "_ir_kept"}, ir_o, ir0);
            chk({name, "_pc"}, pc_model, pc0);
            chk1({name, "_valid"}, ir_valid_o, 1'b0);
            chk1({name, "_fault"}, fault_o, 1'b1);
            plan_q.delete();
        end
        chk1({name, "_rd_idle"}, mem_bus.mem_rd_no, 1'b1);
    endtask

    initial begin
        logic [DW-1:0] pc0;
        logic [DW-1:0] a1;
        logic [DW-1:0] a2;
        int p0, c0, guard;

        reset_ni = 1'b0;
        tick();
        tick();
        reset_ni = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk1("rst_rd", mem_bus.mem_rd_no, 1'b1);
            chk1("rst_inc", pc_inc_no, 1'b1);
            chk("rst_ir", ir_o, 16'h0000);
            chk1("rst_busy", busy_o, 1'b0);
            chk1("rst_valid", ir_valid_o, 1'b0);
            chk1("rst_fault", fault_o, 1'b0);
            tick();
        end

        pc_load(16'h0040);
        run_fetch("zero_wait", 1, 16'hA5C3, 1'b1, 1'b0, '0);

        pc_load(16'h0040);
        run_fetch("wait3", 3, 16'h5A3C, 1'b1, 1'b0, '0);
        chk("wait3_pc_41", pc_model, 16'h0041);

        // Held fetch request: three fetches, one pulse every 4 cycles.
        pc0 = pc_model;
        a1  = pc0 + 16'd1;
        a2  = pc0 + 16'd2;
        p0  = pulse_cnt;
        c0  = pulse_cyc.size();
        plan_q.push_back('{1, 16'h1111});
        plan_q.push_back('{1, 16'h2222});
        plan_q.push_back('{1, 16'h3333});
        exp_q.push_back('{pc0, 16'h1111});
        exp_q.push_back('{a1, 16'h2222});
        exp_q.push_back('{a2, 16'h3333});
        fetch_ni = 1'b0;
        guard = 0;
        while (pulse_cnt < p0 + 3 && guard < 100) begin
            tick();
            guard++;
        end
        fetch_ni = 1'b1;
        wait_idle("b2b_idle");
        chki("b2b_pulses", pulse_cnt, p0 + 3);
        if (pulse_cyc.size() >= c0 + 3) begin
            chki("b2b_gap1", pulse_cyc[c0 + 1] - pulse_cyc[c0], 4);
            chki("b2b_gap2", pulse_cyc[c0 + 2] - pulse_cyc[c0 + 1], 4);
        end else begin
            tests++;
            fails++;
            $display("FAIL b2b_count: got %0d pulses, expected 3", pulse_cyc.size() - c0);
        end
        chk("b2b_pc", pc_model, pc0 + 16'd3);

        // Reset lands on the second WAIT edge of a stalled read.
        p0 = pulse_cnt;
        plan_q.push_back('{1000, 16'hDEAD});
        fetch_ni = 1'b0;
        tick();
        fetch_ni = 1'b1;
        tick();
        tick();
        chk1("midwait_rd_low", mem_bus.mem_rd_no, 1'b0);
        reset_ni = 1'b0;
        tick();
        chk1("midwait_busy", busy_o, 1'b0);
        chk1("midwait_rd", mem_bus.mem_rd_no, 1'b1);
        chk1("midwait_valid", ir_valid_o, 1'b0);
        chk1("midwait_inc", pc_inc_no, 1'b1);
        chk("midwait_ir", ir_o, 16'h0000);
        reset_ni = 1'b1;
        plan_q.delete();
        force_rdy = 1'b1;
        repeat (5) tick();
        force_rdy = 1'b0;
        tick();
        chki("midwait_pulses", pulse_cnt, p0);
        chk1("midwait_busy2", busy_o, 1'b0);
        chk1("midwait_valid2", ir_valid_o, 1'b0);

`ifdef FETCH_TIMEOUT_EN
        run_fetch("timeout", 1000, 16'hBEEF, 1'b0, 1'b0, '0);
        repeat (3) tick();
        chk1("fault_sticky", fault_o, 1'b1);
        run_fetch("after_timeout", 1, 16'h1234, 1'b1, 1'b0, '0);
        run_fetch("rdy_at_limit", TMO, 16'h4321, 1'b1, 1'b0, '0);
`else
        run_fetch("long_wait", 20, 16'h0F0F, 1'b1, 1'b0, '0);
`endif

        run_fetch("mid_load", 2, 16'h7E57, 1'b1, 1'b1, 16'h0300);

        for (int i = 0; i < 24; i++) begin
            run_fetch("rand", int'($urandom_range(1, DMAX)), DW'($urandom),
                      1'b1, ($urandom_range(0, 3) == 0), DW'($urandom));
            repeat ($urandom_range(0, 3)) tick();
        end

        repeat (3) tick();
        chki("sb_drained", exp_q.size(), 0);
        chki("plan_drained", plan_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch stage directly downstream of the program counter.
- Samples the PC value on request and runs a read handshake with instruction memory.
- Latches the returned word into the instruction register, then issues a one-cycle active-low increment pulse back to the PC.
- Control unit starts fetches and reads ir_o / ir_valid_o.

Parameters:
- DATA_WIDTH, 16, width of PC, memory address, memory data and instruction register.
- TIMEOUT_CYCLES, 15, WAIT-state edges before abort (used only with FETCH_TIMEOUT_EN); must be >= 1.

Ports:
- clk_i  input  1  clock; all state changes on falling edge (same as PC).
- reset_ni  input  1  synchronous, active-low reset.
- fetch_ni  input  1  active-low fetch request; honoured only in IDLE.
- pc_i  input  DATA_WIDTH  current PC value.
- pc_inc_no  output  1  active-low increment strobe to PC, one cycle wide.
- mem_addr_o  output  DATA_WIDTH  registered memory address.
- mem_rd_no  output  1  active-low memory read strobe.
- mem_data_i  input  DATA_WIDTH  memory read data.
- mem_rdy_i  input  1  active-high memory ready; data valid when high.
- ir_o  output  DATA_WIDTH  instruction register.
- ir_valid_o  output  1  ir_o holds a freshly fetched word.
- busy_o  output  1  high whenever state != IDLE.
- fault_o  output  1  timeout flag (tied 0 without FETCH_TIMEOUT_EN).

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is synchronous, active-low.
  - All registers update on the falling edge of clk_i.
- Reset (reset_ni=0 at a falling edge, in any state): state=IDLE, mem_addr_o=0, ir_o=0, mem_rd_no=1, pc_inc_no=1, ir_valid_o=0, fault_o=0, timeout counter=0. An in-flight read is abandoned; mem_rd_no is high after that edge.
- States: IDLE, ADDR, WAIT, DONE. Encoding is free; busy_o = (state != IDLE).
- IDLE:
  - Outputs: mem_rd_no=1, pc_inc_no=1.
  - On an edge with fetch_ni=0: mem_addr_o<=pc_i, ir_valid_o<=0, fault_o<=0, go to ADDR.
  - Otherwise hold.
- ADDR: mem_rd_no<=0, counter<=0, go to WAIT. mem_rdy_i is ignored in this state.
- WAIT: mem_rd_no stays 0.
  - Edge with mem_rdy_i=1: ir_o<=mem_data_i, ir_valid_o<=1, mem_rd_no<=1, pc_inc_no<=0, go to DONE.
  - Otherwise: counter increments.
- DONE: pc_inc_no<=1, go to IDLE unconditionally. fetch_ni is ignored here.
- Latency:
  - Fetch accepted at edge N → mem_rd_no low after N+1.
  - Earliest capture is at edge N+2 (rdy sampled high) → pc_inc_no low for exactly one cycle, N+2 to N+3.
  - Next fetch can be accepted at N+4.
  - Minimum period: 4 cycles per fetch.
- PC handshake:
  - The PC samples pc_inc_no=0 at edge N+3 and increments.
  - pc_i is sampled only at fetch accept, so a mid-fetch PC load does not affect the current fetch address.
- ir_o and ir_valid_o:
  - ir_o holds its value until the next successful capture.
  - ir_valid_o stays high until the next accepted fetch.
- Widths: no arithmetic on the datapath. The counter is wide enough for TIMEOUT_CYCLES and saturates, with no wrap-around.
- Held fetch_ni: fetch_ni held low continuously produces back-to-back fetches every 4 cycles.

Optional Feature:
- FETCH_TIMEOUT_EN defined:
  - In WAIT, if counter reaches TIMEOUT_CYCLES with mem_rdy_i=0: mem_rd_no<=1, fault_o<=1, ir_valid_o stays 0, ir_o unchanged, no pc_inc_no pulse, go to IDLE.
  - fault_o is sticky until reset or the next accepted fetch.
  - If mem_rdy_i=1 on the same edge the counter reaches the limit, ready wins and the fetch completes normally.
- FETCH_TIMEOUT_EN undefined: WAIT holds indefinitely, fault_o is constant 0, and no counter logic is synthesised.

Test Plan:
- Reset then idle: reset_ni=0 for 2 edges, fetch_ni=1 → mem_rd_no=1, pc_inc_no=1, ir_o=0x0000, busy_o=0, for 10 cycles.
- Zero-wait fetch: pc_i=0x0040, fetch_ni=0 for 1 edge, mem_rdy_i=1 with mem_data_i=0xA5C3 → mem_addr_o=0x0040, ir_o=0xA5C3 at N+2, pc_inc_no low exactly one cycle, ir_valid_o=1, back in IDLE at N+4.
- Wait states: mem_rdy_i asserted on the 3rd WAIT edge → mem_rd_no low for 3 cycles, a single pc_inc_no pulse; a PC model advances 0x0040→0x0041.
- Back-to-back: fetch_ni held low, memory returns 0x1111, 0x2222, 0x3333 → three captures spaced 4 cycles apart, three pc_inc_no pulses.
- Reset mid-WAIT: reset_ni=0 at the 2nd WAIT edge → IDLE, mem_rd_no=1, ir_valid_o=0, no pc_inc_no pulse; a later mem_rdy_i=1 is ignored.
- FETCH_TIMEOUT_EN with TIMEOUT_CYCLES=4:
  - mem_rdy_i never high → fault_o=1 after 4 WAIT edges, no pc_inc_no pulse.
  - Next fetch clears fault_o.
  - Ready arriving on the 4th WAIT edge completes the fetch and leaves fault_o=0.
